// File: rtl/vm_pkg.sv
// Shared types, defaults and helpers for the parametrised vending controller.
package vm_pkg;

    localparam int MAX_PROD = 16;
    localparam int MAX_CW   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    // Product 0 sits in the low byte: prices are 5, 10, 15, 20.
    localparam logic [31:0] DEFAULT_PRICES = {8'd20, 8'd15, 8'd10, 8'd5};

    // Pulls product id's price out of a packed vector of cw-bit fields.
    function automatic logic [MAX_CW-1:0] get_price(
        input logic [MAX_PROD*MAX_CW-1:0] prices,
        input int unsigned                id,
        input int unsigned                cw
    );
        logic [MAX_PROD*MAX_CW-1:0] shifted;
        logic [MAX_CW:0]            mask;
        shifted = prices >> (id * cw);
        mask    = (33'd1 << cw) - 33'd1;
        return shifted[MAX_CW-1:0] & mask[MAX_CW-1:0];
    endfunction

endpackage

// File: rtl/ven_machine_param_if.sv
// Coin/selection front-end and dispenser/hopper signals of the vending controller.
interface ven_machine_param_if #(
    parameter int NUM_PROD = 4,
    parameter int CW       = 8
);
    localparam int IDW = $clog2(NUM_PROD);

    logic           coin_valid;
    logic [CW-1:0]  coin_val;
    logic           sel_valid;
    logic [IDW-1:0] sel_id;
    logic           cancel;

    logic           vend_valid;
    logic [IDW-1:0] vend_id;
    logic           change_valid;
    logic [CW-1:0]  change_amt;
    logic [CW-1:0]  credit;
    logic           coin_reject;
    logic           err_insuff;
    logic           err_soldout;

    modport master (
        output coin_valid, coin_val, sel_valid, sel_id, cancel,
        input  vend_valid, vend_id, change_valid, change_amt, credit,
               coin_reject, err_insuff, err_soldout
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_id, cancel,
        output vend_valid, vend_id, change_valid, change_amt, credit,
               coin_reject, err_insuff, err_soldout
    );
endinterface

// File: rtl/vm_credit_acc.sv
// Credit register with add/subtract/clear controls; ovf_o flags an add that would wrap.
module vm_credit_acc #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          add_en_i,
    input  logic          sub_en_i,
    input  logic          clr_i,
    input  logic [CW-1:0] add_val_i,
    input  logic [CW-1:0] sub_val_i,
    output logic [CW-1:0] credit_o,
    output logic          ovf_o
);
    logic [CW-1:0] credit_q;
    logic [CW:0]   sum;

    assign sum      = {1'b0, credit_q} + {1'b0, add_val_i};
    assign ovf_o    = sum[CW];
    assign credit_o = credit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= '0;
        end else if (clr_i) begin
            credit_q <= '0;
        end else if (sub_en_i) begin
            credit_q <= credit_q - sub_val_i;
        end else if (add_en_i && !ovf_o) begin
            credit_q <= sum[CW-1:0];
        end
    end
endmodule

// File: rtl/ven_machine_param.sv
// Parametrised vending controller: coin credit, selection, cancel/refund and change.
// Define STOCK_COUNT_EN to enable per-product stock counters and sold-out reporting.
module ven_machine_param
    import vm_pkg::*;
#(
    parameter int                     NUM_PROD   = 4,
    parameter int                     CW         = 8,
    parameter logic [NUM_PROD*CW-1:0] PRICES     = DEFAULT_PRICES,
    parameter int                     STOCK_INIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    ven_machine_param_if.slave bus
);
    localparam int IDW   = $clog2(NUM_PROD);
    localparam int NSLOT = 2 ** IDW;
    localparam logic [MAX_PROD*MAX_CW-1:0] PRICES_EXT = (MAX_PROD*MAX_CW)'(PRICES);

    state_t         state_q;
    logic           vend_valid_q;
    logic [IDW-1:0] vend_id_q;
    logic           change_valid_q;
    logic [CW-1:0]  change_amt_q;
    logic           coin_reject_q;
    logic           err_insuff_q;
    logic           err_soldout_q;

    logic [CW-1:0]    credit;
    logic             acc_ovf;
    logic [CW-1:0]    price_tbl [NSLOT];
    logic [NSLOT-1:0] soldout;
    logic [CW-1:0]    sel_price;

    logic accepting, sel_in_range, sel_live;
    logic do_refund, do_vend, do_insuff, do_soldout, do_add, do_reject, do_vend_change;

    // Unused index slots (non power-of-two NUM_PROD) read as price 0 but are never selectable.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_price
            assign price_tbl[gi] = CW'(get_price(PRICES_EXT, gi, CW));
        end
    endgenerate

`ifdef STOCK_COUNT_EN
    localparam int SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_stock
            if (gi < NUM_PROD) begin : g_cnt
                logic [SW-1:0] cnt_q;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_q <= SW'(STOCK_INIT);
                    end else if (do_vend && bus.sel_id == IDW'(gi)) begin
                        cnt_q <= cnt_q - SW'(1);
                    end
                end
                assign soldout[gi] = (cnt_q == '0);
            end else begin : g_none
                assign soldout[gi] = 1'b1;
            end
        end
    endgenerate
`else
    assign soldout = '0;
`endif

    assign sel_price    = price_tbl[bus.sel_id];
    assign accepting    = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
    assign sel_in_range = 32'(bus.sel_id) < NUM_PROD;

    // Arbitration: cancel beats selection beats coin; a losing coin is rejected.
    assign do_refund  = accepting && bus.cancel && (state_q == ST_CREDIT);
    assign sel_live   = accepting && !bus.cancel && bus.sel_valid && sel_in_range;
    assign do_soldout = sel_live && soldout[bus.sel_id];
    assign do_vend    = sel_live && !soldout[bus.sel_id] && (credit >= sel_price);
    assign do_insuff  = sel_live && !soldout[bus.sel_id] && (credit < sel_price);
    assign do_add     = accepting && !bus.cancel && !bus.sel_valid && bus.coin_valid
                        && (bus.coin_val != '0) && !acc_ovf;
    assign do_reject  = bus.coin_valid
                        && (!accepting || bus.cancel || bus.sel_valid || acc_ovf);
    assign do_vend_change = (state_q == ST_VEND) && (credit != '0);

    vm_credit_acc #(.CW(CW)) u_credit_acc (
        .clk       (clk),
        .reset     (reset),
        .add_en_i  (do_add),
        .sub_en_i  (do_vend),
        .clr_i     (do_refund || (state_q == ST_VEND)),
        .add_val_i (bus.coin_val),
        .sub_val_i (sel_price),
        .credit_o  (credit),
        .ovf_o     (acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            vend_valid_q   <= 1'b0;
            vend_id_q      <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            err_insuff_q   <= 1'b0;
            err_soldout_q  <= 1'b0;
        end else begin
            vend_valid_q   <= do_vend;
            change_valid_q <= do_refund || do_vend_change;
            coin_reject_q  <= do_reject;
            err_insuff_q   <= do_insuff;
            err_soldout_q  <= do_soldout;
            if (do_vend) begin
                vend_id_q <= bus.sel_id;
            end
            if (do_refund || do_vend_change) begin
                change_amt_q <= credit;
            end
            // CHANGE is the cycle in which the change pulse (if any) is visible.
            unique case (state_q)
                ST_IDLE, ST_CREDIT: begin
                    if (do_refund) begin
                        state_q <= ST_CHANGE;
                    end else if (do_vend) begin
                        state_q <= ST_VEND;
                    end else if (do_add) begin
                        state_q <= ST_CREDIT;
                    end
                end
                ST_VEND:   state_q <= ST_CHANGE;
                ST_CHANGE: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_id      = vend_id_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.credit       = credit;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.err_insuff   = err_insuff_q;
    assign bus.err_soldout  = err_soldout_q;
endmodule

// File: tb/tb_ven_machine_param.sv
// Directed plus randomized bench for ven_machine_param with a cycle-level reference model.
module tb_ven_machine_param;
    logic clk;
    logic reset;

    ven_machine_param_if #(.NUM_PROD(4), .CW(8)) bus ();

    ven_machine_param dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: credit, remaining busy cycles after a vend/refund, stock.
    int m_credit;
    int m_busy;
    int m_stock [4];
    int e_vv, e_vid, e_cv, e_amt, e_rej, e_ins, e_so;

    function automatic int price_of(input int id);
        return 5 * (id + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_busy   = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef STOCK_COUNT_EN
            m_stock[i] = 3;
`else
            m_stock[i] = 1000000;
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.coin_valid = 1'b0; bus.coin_val = '0;
        bus.sel_valid  = 1'b0; bus.sel_id   = '0;
        bus.cancel     = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_vend_valid",   32'(bus.vend_valid),   0);
        chk("rst_vend_id",      32'(bus.vend_id),      0);
        chk("rst_change_valid", 32'(bus.change_valid), 0);
        chk("rst_change_amt",   32'(bus.change_amt),   0);
        chk("rst_credit",       32'(bus.credit),       0);
        chk("rst_coin_reject",  32'(bus.coin_reject),  0);
        chk("rst_err_insuff",   32'(bus.err_insuff),   0);
        chk("rst_err_soldout",  32'(bus.err_soldout),  0);
    endtask

    task automatic step(input bit cv, input int cval, input bit sv, input int sid, input bit can);
        @(negedge clk);
        reset = 1'b0;
        bus.coin_valid = cv;  bus.coin_val = cval[7:0];
        bus.sel_valid  = sv;  bus.sel_id   = sid[1:0];
        bus.cancel     = can;
        e_vv = 0; e_cv = 0; e_rej = 0; e_ins = 0; e_so = 0;
        if (m_busy > 0) begin
            e_rej = int'(cv);
            if (m_busy == 2 && m_credit > 0) begin
                e_cv = 1; e_amt = m_credit;
            end
            if (m_busy == 2) m_credit = 0;
            m_busy--;
        end else if (can) begin
            e_rej = int'(cv);
            if (m_credit > 0) begin
                e_cv = 1; e_amt = m_credit; m_credit = 0; m_busy = 1;
            end
        end else if (sv) begin
            e_rej = int'(cv);
            if (m_stock[sid] == 0) begin
                e_so = 1;
            end else if (m_credit >= price_of(sid)) begin
                e_vv = 1; e_vid = sid;
                m_credit -= price_of(sid);
                m_stock[sid]--;
                m_busy = 2;
            end else begin
                e_ins = 1;
            end
        end else if (cv) begin
            if (m_credit + cval > 255) e_rej = 1;
            else m_credit += cval;
        end
        @(posedge clk);
        #1;
        chk("vend_valid",   32'(bus.vend_valid),   e_vv);
        chk("change_valid", 32'(bus.change_valid), e_cv);
        chk("coin_reject",  32'(bus.coin_reject),  e_rej);
        chk("err_insuff",   32'(bus.err_insuff),   e_ins);
        chk("err_soldout",  32'(bus.err_soldout),  e_so);
        chk("credit",       32'(bus.credit),       m_credit);
        if (e_vv == 1) chk("vend_id",    32'(bus.vend_id),    e_vid);
        if (e_cv == 1) chk("change_amt", 32'(bus.change_amt), e_amt);
        $display("cyc cv=%0d val=%0d sv=%0d id=%0d can=%0d -> vv=%0d vid=%0d cv=%0d amt=%0d cr=%0d rej=%0d ins=%0d so=%0d",
                 cv, cval, sv, sid, can, bus.vend_valid, bus.vend_id, bus.change_valid,
                 bus.change_amt, bus.credit, bus.coin_reject, bus.err_insuff, bus.err_soldout);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    int coins [7] = '{0, 1, 5, 10, 25, 50, 100};
    int exp_vend;

    initial begin
        reset = 1'b1;
        bus.coin_valid = 1'b0; bus.coin_val = '0;
        bus.sel_valid  = 1'b0; bus.sel_id   = '0;
        bus.cancel     = 1'b0;
        model_reset();
        do_reset();

        // Coin 5 + 10, buy id1 (10): vend, then change of 5.
        step(1'b1, 5, 1'b0, 0, 1'b0);
        step(1'b1, 10, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 1, 1'b0);
        chk("plan_vend_id1", 32'(bus.vend_id), 1);
        idle();
        chk("plan_change5", 32'(bus.change_amt), 5);
        idle();
        chk("plan_credit0", 32'(bus.credit), 0);

        // Insufficient credit, then cancel refunds.
        step(1'b1, 5, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 3, 1'b0);
        chk("plan_insuff_credit", 32'(bus.credit), 5);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        idle();

        // Overflow rejection at 250 + 10.
        step(1'b1, 100, 1'b0, 0, 1'b0);
        step(1'b1, 100, 1'b0, 0, 1'b0);
        step(1'b1, 50, 1'b0, 0, 1'b0);
        step(1'b1, 10, 1'b0, 0, 1'b0);
        chk("plan_ovf_credit", 32'(bus.credit), 250);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        idle();

        // Cancel beats selection beats coin in the same cycle.
        step(1'b1, 10, 1'b0, 0, 1'b0);
        step(1'b1, 5, 1'b1, 0, 1'b1);
        chk("plan_refund10", 32'(bus.change_amt), 10);
        idle();

        // Exact payment, then reset in the VEND cycle.
        step(1'b1, 15, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 2, 1'b0);
        do_reset();
        idle();

        // Repeated purchases of id0: the fourth is sold out only with stock counting.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 5, 1'b0, 0, 1'b0);
            step(1'b0, 0, 1'b1, 0, 1'b0);
`ifdef STOCK_COUNT_EN
            exp_vend = (k < 3) ? 1 : 0;
`else
            exp_vend = 1;
`endif
            chk("plan_stock_vend", 32'(bus.vend_valid), exp_vend);
            idle();
            idle();
        end
        step(1'b0, 0, 1'b0, 0, 1'b1);
        idle();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 4, coins[$urandom_range(0, 6)],
                     $urandom_range(0, 19) < 3, int'($urandom_range(0, 3)),
                     $urandom_range(0, 19) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ven_machine_param.md
Name: ven_machine_param

Overview:
Parametrised successor to the fixed three-product vending controller. It handles NUM_PROD products with per-product prices set at elaboration, and accumulates coin credit across cycles. It supports cancel/refund and returns change as an explicit one-cycle pulse. It sits between the coin/selection front end and the product dispenser plus change hopper.

Parameters:
NUM_PROD, 4, number of selectable products (2..16)
CW, 8, credit/price/coin width in bits
PRICES, {8'd20,8'd15,8'd10,8'd5}, packed NUM_PROD*CW price vector; product i at bits [i*CW +: CW]
STOCK_INIT, 3, initial units per product (used only with STOCK_COUNT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
coin_valid  in  1  coin inserted this cycle
coin_val  in  CW  coin value
sel_valid  in  1  product selection strobe
sel_id  in  $clog2(NUM_PROD)  selected product index
cancel  in  1  refund request
vend_valid  out  1  one-cycle dispense pulse
vend_id  out  $clog2(NUM_PROD)  product dispensed, valid with vend_valid
change_valid  out  1  one-cycle change pulse
change_amt  out  CW  change amount, valid with change_valid
credit  out  CW  current accumulated credit (registered)
coin_reject  out  1  one-cycle pulse: coin not accepted
err_insuff  out  1  one-cycle pulse: credit < price
err_soldout  out  1  one-cycle pulse: product out of stock (tied 0 without macro)

Behaviour:
- States: IDLE (credit==0), CREDIT, VEND, CHANGE.
- Reset: state=IDLE; credit=0; all pulses=0; vend_id=0; change_amt=0; stock counters=STOCK_INIT. A reset during any state aborts that state; any pending credit is discarded with no refund pulse.
- Same-cycle priority in IDLE/CREDIT: cancel > sel_valid > coin_valid. A coin that loses arbitration is rejected with coin_reject=1 in the next cycle.
- Coin accept (IDLE/CREDIT): credit <= credit+coin_val, then move to CREDIT.
  - If the sum exceeds 2^CW-1, credit is unchanged and coin_reject pulses next cycle.
  - coin_val==0 is accepted as a no-op with no state change.
- Selection, sel_id >= NUM_PROD: ignored with no pulses.
- Selection, credit >= PRICES[sel_id] (and in stock): go to VEND. vend_valid=1 and vend_id=sel_id in cycle N+1; credit <= credit-price in the same cycle.
- Selection, insufficient credit: err_insuff pulses at N+1; the state holds.
- Cancel in CREDIT: go to CHANGE with the full credit.
- Cancel in IDLE: no effect.
- VEND is always followed by CHANGE.
- CHANGE when credit>0: change_valid=1, change_amt=credit, credit<=0, then IDLE. Change pulses at N+2 after a selection, or N+1 after a cancel.
- CHANGE when credit==0: no pulse, go straight to IDLE.
- Inputs during VEND/CHANGE: coins get coin_reject next cycle; sel_valid and cancel are ignored.
- All outputs are registered. At most one of vend_valid or change_valid is high per cycle.

Optional Feature:
STOCK_COUNT_EN:
- Defined: per-product stock counters ($clog2(STOCK_INIT+1) bits), initialised to STOCK_INIT and decremented on each vend_valid.
- Selecting a product with stock==0 gives an err_soldout pulse at N+1, with no vend and credit retained. Sold-out is checked before insufficient credit.
- Undefined: unlimited stock; err_soldout is tied 0.

Decomposition:
- Package vm_pkg holds:
  - state enum localparams (IDLE/CREDIT/VEND/CHANGE)
  - default PRICES vector
  - the price-extract function get_price(PRICES, id)
- One sub-module, vm_credit_acc: saturating-check credit register with add/subtract/clear controls and an overflow flag. The FSM, arbitration and stock counters stay in the top level.

Test Plan:
- Coin 5, coin 10, select id1 (price 10) -> vend_valid id1 at N+1; change_valid amt=5 at N+2; credit=0.
- Coin 5, select id3 (price 20) -> err_insuff pulse; credit stays 5. Then cancel -> change_valid amt=5, state IDLE.
- Coins totalling 250, then coin 10 (CW=8) -> coin_reject pulse; credit stays 250.
- Same cycle: cancel + sel_valid + coin 5 with credit 10 -> refund amt=10, coin_reject, no vend.
- Exact payment: coin 15, select id2 -> vend id2, no change_valid. Then reset asserted mid-VEND -> all outputs 0 and credit 0 the next cycle.
- With STOCK_COUNT_EN, STOCK_INIT=3: buy id0 four times with coin 5 each -> 3 vends; 4th gives err_soldout with credit 5 retained.
